pattern_scan_ctrl: RTL and testbench



---
 rtl/pattern_scan_ctrl_pkg.sv | 26 ++
 rtl/pattern_scan_ctrl_if.sv | 54 +++++
 rtl/pattern_scan_ctrl_det.sv | 52 +++++
 rtl/pattern_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pattern_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl_pkg
// Shared definitions for the "10010" pattern scan controller:
//   - ctrl_state_t : controller sequencing states (IDLE / SHIFT / DONE)
//   - det_state_t  : serial detector states, A = nothing seen ... E = "1001"
//   - PATTERN      : the searched bit pattern, first-received bit is MSB
// ---------------------------------------------------------------------------
package pattern_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ctrl_state_t;

    typedef enum logic [2:0] {
        DET_A = 3'd0,   // no useful prefix
        DET_B = 3'd1,   // "1"
        DET_C = 3'd2,   // "10"
        DET_D = 3'd3,   // "100"
        DET_E = 3'd4    // "1001"
    } det_state_t;

    localparam logic [4:0] PATTERN = 5'b10010;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl_if
// Bundles the producer-side request and the result signals of the scan
// controller.
//   start       : scan request (producer -> controller)
//   data_in     : WIDTH-bit word to scan (producer -> controller)
//   busy        : high while bits are being shifted
//   done        : one-cycle pulse after the last bit
//   match_cnt   : saturating match count of the last/current word
//   match_pulse : registered detector output
//   found / first_idx : only with PATTERN_FIRST_IDX_EN defined
// Modports: master = producer side, slave = controller side.
// ---------------------------------------------------------------------------
interface pattern_scan_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
`ifdef PATTERN_FIRST_IDX_EN
    ,
    parameter int IDX_W = 4
`endif
);

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic             match_pulse;
`ifdef PATTERN_FIRST_IDX_EN
    logic             found;
    logic [IDX_W-1:0] first_idx;

    modport master (
        output start, data_in,
        input  busy, done, match_cnt, match_pulse, found, first_idx
    );

    modport slave (
        input  start, data_in,
        output busy, done, match_cnt, match_pulse, found, first_idx
    );
`else
    modport master (
        output start, data_in,
        input  busy, done, match_cnt, match_pulse
    );

    modport slave (
        input  start, data_in,
        output busy, done, match_cnt, match_pulse
    );
`endif

endinterface

// File: rtl/pattern_scan_ctrl_det.sv
// ---------------------------------------------------------------------------
// seq_det_10010
// Overlapping Mealy detector for the serial pattern "10010".
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (state -> A)
//   clr : synchronous clear (state -> A), has priority over j
//   j   : serial input bit
//   w   : combinational match flag, high in the cycle the final 0 arrives
// After a match the detector continues from "10", so overlapping
// occurrences inside one word are all reported.
// ---------------------------------------------------------------------------
module seq_det_10010
    import pattern_scan_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic j,
    output logic w
);

    det_state_t ps_r;
    det_state_t ns_s;

    // Detector state register with async reset and sync clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_r <= DET_A;
        end else if (clr) begin
            ps_r <= DET_A;
        end else begin
            ps_r <= ns_s;
        end
    end

    // Next-state logic; fall-back states are the longest prefix still valid.
    always_comb begin
        ns_s = ps_r;
        case (ps_r)
            DET_A:   ns_s = (j == PATTERN[4]) ? DET_B : DET_A;
            DET_B:   ns_s = (j == PATTERN[3]) ? DET_C : DET_B;
            DET_C:   ns_s = (j == PATTERN[2]) ? DET_D : DET_B;
            DET_D:   ns_s = (j == PATTERN[1]) ? DET_E : DET_A;
            // Match completes here: its tail "10" is the restart prefix.
            DET_E:   ns_s = (j == PATTERN[0]) ? DET_C : DET_B;
            default: ns_s = DET_A;
        endcase
    end

    assign w = (ps_r == DET_E) && (j == PATTERN[0]);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl
// Latches a WIDTH-bit word on start, feeds it MSB-first into the "10010"
// detector one bit per clock, counts matches (saturating) and pulses done
// one cycle after the last bit.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : pattern_scan_ctrl_if.slave (start, data_in, busy, done,
//         match_cnt, match_pulse [, found, first_idx])
// Optional feature macro: PATTERN_FIRST_IDX_EN adds found/first_idx, which
// record the index (0 = MSB) of the bit that completes the first match.
// ---------------------------------------------------------------------------
module pattern_scan_ctrl
    import pattern_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    pattern_scan_ctrl_if.slave bus
);

    ctrl_state_t      state_r;
    ctrl_state_t      next_state_s;
    logic             accept_s;
    logic [WIDTH-1:0] shreg_r;
    logic [IDX_W-1:0] idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             pulse_r;
    logic             det_w_s;
    logic             in_shift_s;

    assign in_shift_s = (state_r == ST_SHIFT);

    seq_det_10010 u_det (
        .clk (clk),
        .rst (rst),
        .clr (accept_s),
        .j   (shreg_r[WIDTH-1]),
        .w   (det_w_s)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state_s = ST_SHIFT;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (idx_r == IDX_W'(WIDTH - 1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath: word latch/shift, bit index, match counter, status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= '0;
            idx_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            // Flags follow the upcoming state so they are aligned with it.
            busy_r  <= (next_state_s == ST_SHIFT);
            done_r  <= (next_state_s == ST_DONE);
            // The detector keeps clocking outside SHIFT; ignore it there.
            pulse_r <= in_shift_s && det_w_s;
            if (accept_s) begin
                shreg_r <= bus.data_in;
                idx_r   <= '0;
                cnt_r   <= '0;
            end else if (in_shift_s) begin
                shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                idx_r   <= idx_r + IDX_W'(1);
                if (det_w_s && (cnt_r != {CNT_W{1'b1}})) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                shreg_r <= shreg_r;
                idx_r   <= idx_r;
                cnt_r   <= cnt_r;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.match_cnt   = cnt_r;
    assign bus.match_pulse = pulse_r;

`ifdef PATTERN_FIRST_IDX_EN
    logic             found_r;
    logic [IDX_W-1:0] first_idx_r;

    // First-match capture: index of the bit completing the first match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found_r     <= 1'b0;
            first_idx_r <= '0;
        end else if (accept_s) begin
            found_r     <= 1'b0;
            first_idx_r <= '0;
        end else if (in_shift_s && det_w_s && !found_r) begin
            found_r     <= 1'b1;
            first_idx_r <= idx_r;
        end else begin
            found_r     <= found_r;
            first_idx_r <= first_idx_r;
        end
    end

    assign bus.found     = found_r;
    assign bus.first_idx = first_idx_r;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pattern_scan_ctrl
// Self-checking bench: a table of known words, randomized words against a
// window-based reference model, and hand-written corner sequences (start
// held high, start noise during a scan, reset mid-scan). A second instance
// with CNT_W=2 checks counter saturation on the same stimulus.
// ---------------------------------------------------------------------------
module tb_pattern_scan_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam int IDX_W = 4;
    localparam logic [4:0] PAT = 5'b10010;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef PATTERN_FIRST_IDX_EN
    pattern_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();
    pattern_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(2),     .IDX_W(IDX_W)) bus2 ();
`else
    pattern_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    pattern_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(2))     bus2 ();
`endif

    pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(2), .IDX_W(IDX_W)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    assign bus2.start   = bus.start;
    assign bus2.data_in = bus.data_in;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a match completes at bit index k (0 = MSB) when the
    // five bits ending at k read as the pattern.
    function automatic bit hit_at(input logic [15:0] w, input int k);
        logic [4:0] win;
        if (k < 4 || k > 15) return 1'b0;
        win = w[19-k -: 5];
        return (win == PAT);
    endfunction

    function automatic int model_count(input logic [15:0] w, input int upto);
        int n = 0;
        for (int k = 0; k <= upto; k++) if (hit_at(w, k)) n++;
        return n;
    endfunction

    function automatic int model_first(input logic [15:0] w);
        for (int k = 0; k < 16; k++) if (hit_at(w, k)) return k;
        return -1;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    // One scan: mode 0 = start low during scan, 1 = start held high
    // (restart after DONE), 2 = random start/data noise during scan.
    task automatic do_scan(input logic [15:0] word, input int mode, input int exp_cnt,
                           input int exp_cnt2, input int exp_found, input int exp_first,
                           input string tag);
        bit seen;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = word;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            check({tag, "/busy"}, 32'(bus.busy), 32'(c <= 16));
            check({tag, "/done"}, 32'(bus.done), 32'(c == 17));
            check({tag, "/pulse"}, 32'(bus.match_pulse),
                  32'((c >= 2) && hit_at(word, c - 2)));
            if (c == 17 || c == 18) begin
                check({tag, "/cnt"}, 32'(bus.match_cnt), 32'(exp_cnt));
                check({tag, "/cnt_sat"}, 32'(bus2.match_cnt), 32'(exp_cnt2));
`ifdef PATTERN_FIRST_IDX_EN
                check({tag, "/found"}, 32'(bus.found), 32'(exp_found));
                check({tag, "/first_idx"}, 32'(bus.first_idx), 32'(exp_first));
`endif
            end
            if (c == 18) begin
                bus.start   = (mode == 1);
                bus.data_in = word;
            end else begin
                case (mode)
                    0:       bus.start = 1'b0;
                    1:       bus.start = 1'b1;
                    2:       bus.start = 1'($urandom_range(0, 1));
                    default: bus.start = 1'b0;
                endcase
                bus.data_in = 16'($urandom);
            end
        end
        if (mode == 1) begin
            @(negedge clk);
            check({tag, "/restart_busy"}, 32'(bus.busy), 32'd1);
            bus.start = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.done) seen = 1'b1;
            end
            check({tag, "/restart_done"}, 32'(seen), 32'd1);
            check({tag, "/restart_cnt"}, 32'(bus.match_cnt), 32'(exp_cnt));
        end
    endtask

    typedef struct {
        logic [15:0] word;
        int          cnt;
        int          cnt2;
        int          found;
        int          first;
        string       name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit          saw_done;
        logic [15:0] w;
        int          m;
        int          f;

        vecs[0] = '{16'h9200, 2, 2, 1, 4,  "v9200"};
        vecs[1] = '{16'h9249, 4, 3, 1, 4,  "v9249"};
        vecs[2] = '{16'h0000, 0, 0, 0, 0,  "v0000"};
        vecs[3] = '{16'hFFFF, 0, 0, 0, 0,  "vFFFF"};
        vecs[4] = '{16'h0012, 1, 1, 1, 15, "v0012"};
        vecs[5] = '{16'h4800, 1, 1, 1, 5,  "v4800"};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/done", 32'(bus.done), 32'd0);
        check("rst/cnt", 32'(bus.match_cnt), 32'd0);
        check("rst/pulse", 32'(bus.match_pulse), 32'd0);
`ifdef PATTERN_FIRST_IDX_EN
        check("rst/found", 32'(bus.found), 32'd0);
        check("rst/first_idx", 32'(bus.first_idx), 32'd0);
`endif
        rst = 1'b0;

        // Known words; 0012 followed by 4800 shows the detector is cleared.
        for (int i = 0; i < 6; i++)
            do_scan(vecs[i].word, 0, vecs[i].cnt, vecs[i].cnt2,
                    vecs[i].found, vecs[i].first, vecs[i].name);

        // start held high across a whole scan, then an immediate restart.
        do_scan(16'h9249, 1, 4, 3, 1, 4, "hold_start");
        // start and data noise during SHIFT/DONE must be ignored.
        do_scan(16'h9200, 2, 2, 2, 1, 4, "noise_start");

        // Reset in SHIFT cycle 8, with start asserted alongside.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 16'h9200;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("midrst/pre_busy", 32'(bus.busy), 32'd1);
        check("midrst/pre_cnt", 32'(bus.match_cnt), 32'(model_count(16'h9200, 6)));
        rst       = 1'b1;
        bus.start = 1'b1;
        #1;
        check("midrst/busy", 32'(bus.busy), 32'd0);
        check("midrst/cnt", 32'(bus.match_cnt), 32'd0);
        check("midrst/pulse", 32'(bus.match_pulse), 32'd0);
        check("midrst/done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("midrst/rst_wins", 32'(bus.busy), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        saw_done  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("midrst/no_done", 32'(saw_done), 32'd0);
        do_scan(16'h9200, 0, 2, 2, 1, 4, "after_rst");

        // Randomized words against the reference model.
        for (int i = 0; i < 24; i++) begin
            w = 16'($urandom);
            if (i % 4 == 0) w[15 - (i % 11) -: 5] = PAT;
            m = model_count(w, 15);
            f = model_first(w);
            do_scan(w, (i % 3 == 0) ? 2 : 0, sat(m, 31), sat(m, 3),
                    (f >= 0) ? 1 : 0, (f >= 0) ? f : 0, $sformatf("rnd%0d_%h", i, w));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
